// File: rtl/engine_arb_pkg.sv
// Shared types and constants for the two-requester engine arbiter.
package engine_arb_pkg;

  localparam int unsigned CNT_W         = 3;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWNED = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  // One-hot grant/done vector for a requester index.
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/burst_counter.sv
// Saturating count of engine ops run by the current owner.
//   clk, rst : clock, async active-low reset
//   inc      : count one completed op (holds at MAX)
//   clr      : clear to zero, wins over inc
//   sat      : registered flag, count == MAX
module burst_counter
  import engine_arb_pkg::*;
#(
  parameter int unsigned MAX = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: clear first, otherwise increment only below MAX.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= (cnt_nxt == MAX_C);
    end
  end

endmodule

// File: rtl/engine_arbiter.sv
// Arbitrates two requesters for one shared engine with burst fairness.
//   clk, rst  : clock, async active-low reset
//   req       : per-requester level request
//   opStart   : per-requester op launch pulse (honoured only from owner in OWNED)
//   engDone   : engine completion level (honoured only in BUSY)
//   gnt       : one-hot or zero ownership
//   engStart  : one-cycle engine start pulse
//   opDone    : one-cycle completion pulse to owner
//   busy      : op in flight
module engine_arbiter
  import engine_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] opStart,
  input  logic       engDone,
  output logic [1:0] gnt,
  output logic       engStart,
  output logic [1:0] opDone,
  output logic       busy
);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_owner, last_nxt;
  logic       other;
  logic       pref;
  logic       cnt_inc, cnt_clr, sat;
  logic [1:0] gnt_nxt;
  logic [1:0] opdone_nxt;
  logic       engstart_nxt;
  logic       busy_nxt;

  assign other = ~owner;
  assign pref  = ~last_owner;

  burst_counter #(.MAX(MAX_BURST)) u_burst (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (sat)
  );

  // Next state, owner bookkeeping and next registered outputs.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last_owner;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    opdone_nxt = 2'b00;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          // Prefer the requester that did not own last time.
          owner_nxt = req[pref] ? pref : last_owner;
          state_nxt = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (opStart[owner]) begin
          state_nxt = ST_START;
        end else if (!req[owner]) begin
          state_nxt = ST_REL;
        end else if (sat && req[other]) begin
          state_nxt = ST_REL;
        end
        // Burst used up with nobody waiting: start a fresh burst.
        if (sat && !req[other]) begin
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (engDone) begin
          state_nxt  = ST_OWNED;
          cnt_inc    = 1'b1;
          opdone_nxt = onehot2(owner);
        end
      end
      ST_REL: begin
        state_nxt = ST_IDLE;
        last_nxt  = owner;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Moore decode of the upcoming state so the outputs can be registered.
    gnt_nxt      = 2'b00;
    engstart_nxt = (state_nxt == ST_START);
    busy_nxt     = (state_nxt == ST_START) || (state_nxt == ST_BUSY);
    if ((state_nxt == ST_OWNED) || busy_nxt) begin
      gnt_nxt = onehot2(owner_nxt);
    end
  end

  // State, owner history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt        <= 2'b00;
      engStart   <= 1'b0;
      opDone     <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      gnt        <= gnt_nxt;
      engStart   <= engstart_nxt;
      opDone     <= opdone_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_engine_arbiter.sv
// Directed self-checking bench for engine_arbiter (MAX_BURST = 4).
module tb_engine_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] opStart;
  logic       engDone;
  logic [1:0] gnt;
  logic       engStart;
  logic [1:0] opDone;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;

  engine_arbiter #(.MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .opStart  (opStart),
    .engDone  (engDone),
    .gnt      (gnt),
    .engStart (engStart),
    .opDone   (opDone),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req     = 2'b00;
    opStart = 2'b00;
    engDone = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),      32'h0);
    chk("rst_start", 32'(engStart), 32'h0);
    chk("rst_done",  32'(opDone),   32'h0);
    chk("rst_busy",  32'(busy),     32'h0);
    step();
    step();
    rst = 1'b1;
  endtask

  // Launch one op from the owner, finish it after wait_n BUSY cycles.
  task automatic do_op(input logic who, input int wait_n, input string tag);
    logic [1:0] oh;
    oh = who ? 2'b10 : 2'b01;
    opStart = oh;
    step();
    opStart = 2'b00;
    chk({tag, "_estart"}, 32'(engStart), 32'h1);
    chk({tag, "_busy0"},  32'(busy),     32'h1);
    chk({tag, "_gnt0"},   32'(gnt),      32'(oh));
    for (int i = 0; i < wait_n; i++) begin
      step();
      chk({tag, "_estart_lo"}, 32'(engStart), 32'h0);
      chk({tag, "_busy"},      32'(busy),     32'h1);
      if (i == wait_n - 1) engDone = 1'b1;
    end
    step();
    engDone = 1'b0;
    chk({tag, "_opdone"}, 32'(opDone), 32'(oh));
    chk({tag, "_busy_lo"}, 32'(busy),  32'h0);
    chk({tag, "_gnt1"},   32'(gnt),    32'(oh));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Single requester, engDone after 3 BUSY cycles.
    do_reset();
    req = 2'b01;
    step();
    chk("single_gnt", 32'(gnt), 32'h1);
    do_op(1'b0, 3, "single");
    step();
    chk("single_done_lo", 32'(opDone), 32'h0);
    chk("single_hold",    32'(gnt),    32'h1);
    req = 2'b00;
    step();
    chk("single_rel", 32'(gnt), 32'h0);
    step();
    // lastOwner is now 0: a tie goes to requester 1.
    req = 2'b11;
    step();
    chk("tie_last0", 32'(gnt), 32'h2);
    req = 2'b00;
    step();
    step();

    // Tie straight after reset: requester 0 wins, dead cycles, then 1.
    do_reset();
    req = 2'b11;
    step();
    chk("tie_rst", 32'(gnt), 32'h1);
    req = 2'b10;
    step();
    chk("tie_rel", 32'(gnt), 32'h0);
    step();
    chk("tie_idle", 32'(gnt), 32'h0);
    step();
    chk("tie_hand", 32'(gnt), 32'h2);
    req = 2'b00;
    step();
    step();

    // Burst fairness with the other requester waiting.
    do_reset();
    req = 2'b11;
    step();
    chk("burst_gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) do_op(1'b0, 1, "burst");
    step();
    chk("burst_rel", 32'(gnt), 32'h0);
    step();
    chk("burst_idle", 32'(gnt), 32'h0);
    step();
    chk("burst_hand", 32'(gnt), 32'h2);
    // Requester 1 leaves; requester 0 alone gets an unbounded run.
    req = 2'b01;
    step();
    chk("solo_rel", 32'(gnt), 32'h0);
    step();
    step();
    chk("solo_gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) do_op(1'b0, 1, "solo");
    step();
    chk("solo_keep", 32'(gnt), 32'h1);
    do_op(1'b0, 2, "solo5");

    // Illegal starts and stray engDone.
    opStart = 2'b10;
    step();
    opStart = 2'b00;
    chk("ill_other_start", 32'(engStart), 32'h0);
    chk("ill_other_busy",  32'(busy),     32'h0);
    chk("ill_other_gnt",   32'(gnt),      32'h1);
    engDone = 1'b1;
    step();
    engDone = 1'b0;
    chk("ill_done_op",   32'(opDone), 32'h0);
    chk("ill_done_busy", 32'(busy),   32'h0);
    opStart = 2'b01;
    step();
    opStart = 2'b00;
    chk("ill_legal_start", 32'(engStart), 32'h1);
    step();
    opStart = 2'b01;
    step();
    opStart = 2'b00;
    chk("ill_busy_start", 32'(engStart), 32'h0);
    chk("ill_busy_busy",  32'(busy),     32'h1);
    chk("ill_busy_gnt",   32'(gnt),      32'h1);
    engDone = 1'b1;
    step();
    engDone = 1'b0;
    chk("ill_busy_done", 32'(opDone), 32'h1);

    // Reset in the middle of an op.
    do_reset();
    req = 2'b01;
    step();
    opStart = 2'b01;
    step();
    opStart = 2'b00;
    step();
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_async_gnt",  32'(gnt),  32'h0);
    chk("mid_async_busy", 32'(busy), 32'h0);
    req = 2'b00;
    step();
    rst = 1'b1;
    engDone = 1'b1;
    step();
    engDone = 1'b0;
    chk("mid_done",  32'(opDone),   32'h0);
    chk("mid_busy2", 32'(busy),     32'h0);
    chk("mid_gnt",   32'(gnt),      32'h0);
    chk("mid_start", 32'(engStart), 32'h0);
    req = 2'b11;
    step();
    chk("mid_tie", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    step();

    // Owner drops req while BUSY; op still completes, then handover.
    do_reset();
    req = 2'b01;
    step();
    opStart = 2'b01;
    step();
    opStart = 2'b00;
    step();
    req = 2'b10;
    step();
    chk("drop_busy", 32'(busy), 32'h1);
    engDone = 1'b1;
    step();
    engDone = 1'b0;
    chk("drop_done", 32'(opDone), 32'h1);
    chk("drop_gnt",  32'(gnt),    32'h1);
    step();
    chk("drop_rel",     32'(gnt),    32'h0);
    chk("drop_done_lo", 32'(opDone), 32'h0);
    step();
    chk("drop_idle", 32'(gnt), 32'h0);
    step();
    chk("drop_hand", 32'(gnt), 32'h2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
